// File: rtl/vproc_pkg.sv
// vproc_pkg: shared constants and the rotating-priority helper used by port arbiters.
//   VRF_WR_LAT    cycles from accept to VRF write enable
//   RR_MAX_N      largest requester count rr_first_idx supports
//   rr_first_idx  first set bit of req at or after ptr, wrapping below n; 0 when none set
package vproc_pkg;

    localparam int unsigned VRF_WR_LAT = 1;
    localparam int unsigned RR_MAX_N   = 32;

    function automatic int unsigned rr_first_idx(
        input logic [RR_MAX_N-1:0] req,
        input int unsigned         ptr,
        input int unsigned         n
    );
        int unsigned idx;
        int unsigned j;
        logic        found;
        idx   = 0;
        found = 1'b0;
        // Scanning from ptr upward and wrapping covers "i >= ptr first, then i < ptr".
        for (int unsigned k = 0; k < RR_MAX_N; k++) begin
            j = ptr + k;
            if (j >= n) j = j - n;
            if (k < n && !found && req[j[4:0]]) begin
                idx   = j;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/vproc_rr_arbiter.sv
// vproc_rr_arbiter: combinational round-robin pick among N requesters.
//   req_i    request vector
//   ptr_i    highest-priority index this cycle
//   grant_o  one-hot grant, zero when no request
//   idx_o    index of the granted requester (0 when none)
module vproc_rr_arbiter
    import vproc_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        idx_o   = IDX_W'(rr_first_idx(RR_MAX_N'(req_i), 32'(ptr_i), N));
        grant_o = req_i & (N'(1) << idx_o);
    end

endmodule

// File: rtl/vproc_vreg_wr_arbiter.sv
// vproc_vreg_wr_arbiter: shares the VRF write port among PIPE_CNT pipelines.
//   clk_i, async_rst_ni, sync_rst_ni   clock, async and sync active-low resets
//   req_valid_i / req_ready_o          per-pipeline write handshake
//   req_addr_i, req_data_i, req_be_i   per-pipeline write fields (flattened, pipe 0 lowest)
//   req_last_i                         write is the instruction's last for this vreg
//   vreg_wr_en_o / vreg_wr_ready_i     registered VRF write port with back-pressure
//   vreg_wr_addr_o/_data_o/_be_o       VRF write fields
//   pend_vreg_wr_clr_o                 one-hot clear of the pending-write map on last commit
module vproc_vreg_wr_arbiter
    import vproc_pkg::*;
#(
    parameter int unsigned PIPE_CNT       = 4,
    parameter int unsigned MAX_VADDR_W    = 5,
    parameter int unsigned VREG_W         = 128,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                            clk_i,
    input  logic                            async_rst_ni,
    input  logic                            sync_rst_ni,
    input  logic [PIPE_CNT-1:0]             req_valid_i,
    output logic [PIPE_CNT-1:0]             req_ready_o,
    input  logic [PIPE_CNT*MAX_VADDR_W-1:0] req_addr_i,
    input  logic [PIPE_CNT*VREG_W-1:0]      req_data_i,
    input  logic [PIPE_CNT*VREG_W/8-1:0]    req_be_i,
    input  logic [PIPE_CNT-1:0]             req_last_i,
    output logic                            vreg_wr_en_o,
    input  logic                            vreg_wr_ready_i,
    output logic [MAX_VADDR_W-1:0]          vreg_wr_addr_o,
    output logic [VREG_W-1:0]               vreg_wr_data_o,
    output logic [VREG_W/8-1:0]             vreg_wr_be_o,
    output logic [(1<<MAX_VADDR_W)-1:0]     pend_vreg_wr_clr_o
);

    localparam int unsigned VADDR_CNT = 1 << MAX_VADDR_W;
    localparam int unsigned BE_W      = VREG_W / 8;
    localparam int unsigned IDX_W     = PIPE_CNT > 1 ? $clog2(PIPE_CNT) : 1;

    logic                   run;
    logic                   stage_free;
    logic                   accept;
    logic [PIPE_CNT-1:0]    grant;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [IDX_W-1:0]       rr_ptr_d;
    logic                   out_valid_q;
    logic                   out_last_q;
    logic [MAX_VADDR_W-1:0] out_addr_q;
    logic [VREG_W-1:0]      out_data_q;
    logic [BE_W-1:0]        out_be_q;

    vproc_rr_arbiter #(.N(PIPE_CNT)) rr_arb (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (idx)
    );

    // While either reset is asserted the port is silent: no handshakes, no write, no clear,
    // so a write held in the stage is dropped without ever reaching the VRF.
    always_comb begin
        run                = async_rst_ni & sync_rst_ni;
        stage_free         = ~out_valid_q | vreg_wr_ready_i;
        req_ready_o        = grant & {PIPE_CNT{stage_free & run}};
        accept             = |req_ready_o;
        rr_ptr_d           = (idx == IDX_W'(PIPE_CNT - 1)) ? '0 : idx + IDX_W'(1);
        vreg_wr_en_o       = out_valid_q & run;
        vreg_wr_addr_o     = (DONT_CARE_ZERO && !vreg_wr_en_o) ? '0 : out_addr_q;
        vreg_wr_data_o     = (DONT_CARE_ZERO && !vreg_wr_en_o) ? '0 : out_data_q;
        vreg_wr_be_o       = (DONT_CARE_ZERO && !vreg_wr_en_o) ? '0 : out_be_q;
        pend_vreg_wr_clr_o = (vreg_wr_en_o & out_last_q & vreg_wr_ready_i)
                             ? VADDR_CNT'(1) << out_addr_q : '0;
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_be_q    <= '0;
        end else if (!sync_rst_ni) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_be_q    <= '0;
        end else if (accept) begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= 1'b1;
            out_last_q  <= req_last_i[idx];
            out_addr_q  <= req_addr_i[idx*MAX_VADDR_W +: MAX_VADDR_W];
            out_data_q  <= req_data_i[idx*VREG_W +: VREG_W];
            out_be_q    <= req_be_i[idx*BE_W +: BE_W];
        end else if (vreg_wr_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    // A requester must hold its request until it is accepted.
    for (genvar i = 0; i < PIPE_CNT; i++) begin : g_hold
        assert property (@(posedge clk_i) disable iff (!async_rst_ni || !sync_rst_ni)
                         req_valid_i[i] && !req_ready_o[i] |=> req_valid_i[i]);
    end

endmodule

// File: tb/tb_vproc_vreg_wr_arbiter.sv
// tb_vproc_vreg_wr_arbiter: table-driven check of the VRF write arbiter plus reset sequences.
module tb_vproc_vreg_wr_arbiter;

    localparam int P  = 4;
    localparam int AW = 5;
    localparam int W  = 128;
    localparam int BW = W / 8;

    logic clk = 1'b0;
    logic async_rst_n = 1'b0;
    logic sync_rst_n = 1'b1;
    logic [P-1:0] valid = '0;
    logic [P-1:0] ready;
    logic [P-1:0] last = '0;
    logic [P-1:0][AW-1:0] adr = '0;
    logic rdy = 1'b1;
    logic [P*AW-1:0] addr_flat;
    logic [P*W-1:0] data_flat;
    logic [P*BW-1:0] be_flat;
    logic en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic [BW-1:0] wr_be;
    logic [31:0] clr;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk_data(input int p, input logic [AW-1:0] a);
        logic [31:0] w;
        w = {4'hD, 4'(p), 3'b0, a, 16'hC0DE};
        return {4{w}};
    endfunction

    function automatic logic [BW-1:0] mk_be(input int p);
        logic [BW-1:0] b;
        b = 16'h0101;
        return b << p;
    endfunction

    always_comb begin
        addr_flat = '0;
        data_flat = '0;
        be_flat   = '0;
        for (int p = 0; p < P; p++) begin
            addr_flat[p*AW +: AW] = adr[p];
            data_flat[p*W +: W]   = mk_data(p, adr[p]);
            be_flat[p*BW +: BW]   = mk_be(p);
        end
    end

    vproc_vreg_wr_arbiter #(.PIPE_CNT(P), .MAX_VADDR_W(AW), .VREG_W(W), .DONT_CARE_ZERO(1'b0)) dut (
        .clk_i              (clk),
        .async_rst_ni       (async_rst_n),
        .sync_rst_ni        (sync_rst_n),
        .req_valid_i        (valid),
        .req_ready_o        (ready),
        .req_addr_i         (addr_flat),
        .req_data_i         (data_flat),
        .req_be_i           (be_flat),
        .req_last_i         (last),
        .vreg_wr_en_o       (en),
        .vreg_wr_ready_i    (rdy),
        .vreg_wr_addr_o     (wr_addr),
        .vreg_wr_data_o     (wr_data),
        .vreg_wr_be_o       (wr_be),
        .pend_vreg_wr_clr_o (clr)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]      v;
        logic            rdy;
        logic [3:0]      last;
        logic [3:0][4:0] adr;
        logic [3:0]      e_ready;
        logic            e_en;
        int              e_pipe;
        logic [4:0]      e_addr;
        logic [31:0]     e_clr;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic [3:0] v, input logic r, input logic [3:0] l,
                                input logic [3:0][4:0] a, input logic [3:0] er, input logic ee,
                                input int ep, input logic [4:0] ea, input logic [31:0] ec);
        vec_t t;
        t.v = v; t.rdy = r; t.last = l; t.adr = a;
        t.e_ready = er; t.e_en = ee; t.e_pipe = ep; t.e_addr = ea; t.e_clr = ec;
        return t;
    endfunction

    initial begin
        logic [3:0][4:0] d, s4, s5;
        d  = {5'd4, 5'd3, 5'd2, 5'd1};
        s4 = {5'd4, 5'd5, 5'd2, 5'd1};
        s5 = {5'd4, 5'd3, 5'd7, 5'd1};
        // all four request: grants 0,1,2,3,0
        tbl[0]  = mk(4'b1111, 1, 4'b0000, d,  4'b0001, 0, 0, 0, 0);
        tbl[1]  = mk(4'b1111, 1, 4'b0000, d,  4'b0010, 1, 0, 1, 0);
        tbl[2]  = mk(4'b1111, 1, 4'b0000, d,  4'b0100, 1, 1, 2, 0);
        tbl[3]  = mk(4'b1011, 1, 4'b0000, d,  4'b1000, 1, 2, 3, 0);
        tbl[4]  = mk(4'b0011, 1, 4'b0000, d,  4'b0001, 1, 3, 4, 0);
        // pipes 1 and 3 with rr at 2: 3 first, then 1
        tbl[5]  = mk(4'b0010, 1, 4'b0000, d,  4'b0010, 1, 0, 1, 0);
        tbl[6]  = mk(4'b1010, 1, 4'b0000, d,  4'b1000, 1, 1, 2, 0);
        tbl[7]  = mk(4'b0010, 1, 4'b0000, d,  4'b0010, 1, 3, 4, 0);
        tbl[8]  = mk(4'b0000, 1, 4'b0000, d,  4'b0000, 1, 1, 2, 0);
        tbl[9]  = mk(4'b0000, 1, 4'b0000, d,  4'b0000, 0, 0, 0, 0);
        tbl[10] = mk(4'b1010, 1, 4'b0000, d,  4'b1000, 0, 0, 0, 0);
        tbl[11] = mk(4'b0010, 1, 4'b0000, d,  4'b0010, 1, 3, 4, 0);
        tbl[12] = mk(4'b0000, 1, 4'b0000, d,  4'b0000, 1, 1, 2, 0);
        tbl[13] = mk(4'b0000, 1, 4'b0000, d,  4'b0000, 0, 0, 0, 0);
        // pipe 2 last write to vreg 5 under back-pressure
        tbl[14] = mk(4'b0100, 1, 4'b0100, s4, 4'b0100, 0, 0, 0, 0);
        tbl[15] = mk(4'b0001, 0, 4'b0100, s4, 4'b0000, 1, 2, 5, 0);
        tbl[16] = mk(4'b0001, 0, 4'b0100, s4, 4'b0000, 1, 2, 5, 0);
        tbl[17] = mk(4'b0001, 0, 4'b0100, s4, 4'b0000, 1, 2, 5, 0);
        tbl[18] = mk(4'b0001, 1, 4'b0100, s4, 4'b0001, 1, 2, 5, 32'h20);
        tbl[19] = mk(4'b0000, 1, 4'b0100, s4, 4'b0000, 1, 0, 1, 0);
        // non-last then last write to vreg 7
        tbl[20] = mk(4'b0010, 1, 4'b0000, s5, 4'b0010, 0, 0, 0, 0);
        tbl[21] = mk(4'b0010, 1, 4'b0010, s5, 4'b0010, 1, 1, 7, 0);
        tbl[22] = mk(4'b0000, 1, 4'b0010, s5, 4'b0000, 1, 1, 7, 32'h80);
        tbl[23] = mk(4'b0000, 1, 4'b0000, s5, 4'b0000, 0, 0, 0, 0);

        // async reset held with random requests
        adr = d;
        for (int c = 0; c < 3; c++) begin
            step();
            valid = 4'($urandom);
            #1;
            chk("rst_ready", ready, 0);
            chk("rst_en", en, 0);
            chk("rst_addr", wr_addr, 0);
            chk("rst_data", wr_data, 0);
            chk("rst_be", wr_be, 0);
            chk("rst_clr", clr, 0);
        end
        step();
        valid = 4'b1111;
        async_rst_n = 1'b1;

        for (int r = 0; r < 24; r++) begin
            valid = tbl[r].v;
            rdy   = tbl[r].rdy;
            last  = tbl[r].last;
            adr   = tbl[r].adr;
            #1;
            chk($sformatf("r%0d_ready", r), ready, tbl[r].e_ready);
            chk($sformatf("r%0d_en", r), en, tbl[r].e_en);
            if (tbl[r].e_en) begin
                chk($sformatf("r%0d_addr", r), wr_addr, tbl[r].e_addr);
                chk($sformatf("r%0d_data", r), wr_data, mk_data(tbl[r].e_pipe, tbl[r].e_addr));
                chk($sformatf("r%0d_be", r), wr_be, mk_be(tbl[r].e_pipe));
            end
            chk($sformatf("r%0d_clr", r), clr, tbl[r].e_clr);
            step();
        end

        // sync reset while the stage holds a last write to vreg 7
        last = 4'b0010; adr = s5; valid = 4'b0010; rdy = 1'b0;
        #1;
        chk("sr_accept", ready, 4'b0010);
        step();
        valid = '0;
        #1;
        chk("sr_held_en", en, 1);
        chk("sr_held_addr", wr_addr, 7);
        chk("sr_held_clr", clr, 0);
        step();
        sync_rst_n = 1'b0; rdy = 1'b1;
        #1;
        chk("sr_in_clr", clr, 0);
        chk("sr_in_en", en, 0);
        chk("sr_in_ready", ready, 0);
        step();
        sync_rst_n = 1'b1;
        #1;
        chk("sr_after_en", en, 0);
        chk("sr_after_clr", clr, 0);
        last = '0; valid = 4'b1010;
        #1;
        chk("sr_rr_zero", ready, 4'b0010);
        step();
        valid = 4'b1000;
        #1;
        chk("sr_next_ready", ready, 4'b1000);
        chk("sr_next_en", en, 1);
        chk("sr_next_data", wr_data, mk_data(1, 7));
        step();
        valid = '0;
        step();
        step();
        #1;
        chk("sr_idle_en", en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
